// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, h/v position counters,
// blanking, sync pulses and line/frame start strobes. Every output is a
// flop loaded from the next-state position, so position, blanking and
// sync always describe the same pixel in the same clk.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_VIS + H_FP;
  localparam int unsigned HS_END  = H_VIS + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_VIS + V_FP;
  localparam int unsigned VS_END  = V_VIS + V_FP + V_SYNC;
  localparam logic        SYNC_ON = 1'(SYNC_POL);

  // Elaboration-time legality checks on the timing parameters
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_tot_chk
    $error("vga_sync_gen: H_TOT/V_TOT exceed 10-bit counter range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("vga_sync_gen: CLK_DIV outside 1..16");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;
  logic             first_q, first_d;
  logic [POS_W-1:0] pixel_x_q, pixel_x_d;
  logic [POS_W-1:0] pixel_y_q, pixel_y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Next-state: divider, position walk and outputs derived from next position
  always_comb begin
    div_cnt_d     = div_cnt_q + DIV_W'(1);
    p_tick_d      = 1'b0;
    first_d       = first_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
      div_cnt_d = '0;
      p_tick_d  = 1'b1;
    end

    if (p_tick_d) begin
      // The (0,0) held through reset is shown on the first tick, not skipped
      first_d = 1'b0;
      if (!first_q) begin
        if (pixel_x_q == POS_W'(H_TOT - 1)) begin
          pixel_x_d    = '0;
          line_start_d = 1'b1;
          if (pixel_y_q == POS_W'(V_TOT - 1)) begin
            pixel_y_d     = '0;
            frame_start_d = 1'b1;
          end else begin
            pixel_y_d = pixel_y_q + POS_W'(1);
          end
        end else begin
          pixel_x_d = pixel_x_q + POS_W'(1);
        end
      end
      video_on_d = (pixel_x_d < POS_W'(H_VIS)) && (pixel_y_d < POS_W'(V_VIS));
      hsync_d    = ((pixel_x_d >= POS_W'(HS_BEG)) && (pixel_x_d < POS_W'(HS_END)))
                   ? SYNC_ON : ~SYNC_ON;
      vsync_d    = ((pixel_y_d >= POS_W'(VS_BEG)) && (pixel_y_d < POS_W'(VS_END)))
                   ? SYNC_ON : ~SYNC_ON;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      p_tick_q      <= 1'b0;
      first_q       <= 1'b1;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      p_tick_q      <= p_tick_d;
      first_q       <= first_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a small-geometry
// CLK_DIV=1 / positive-sync instance, both compared every clk against an
// arithmetic model of position as a function of clks since reset release.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       p_tick_a, video_on_a, hsync_a, vsync_a, line_start_a, frame_start_a;
  logic [9:0] pixel_x_a, pixel_y_a;
  logic       p_tick_b, video_on_b, hsync_b, vsync_b, line_start_b, frame_start_b;
  logic [9:0] pixel_x_b, pixel_y_b;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .p_tick(p_tick_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VIS(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .p_tick(p_tick_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  typedef struct {
    bit tick;
    int x;
    int y;
    bit von;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int n_a   = 0;
  int n_b   = 0;
  bit win   = 1'b0;
  bit have_prev = 1'b0;
  logic [22:0] prev_a;
  int c_von_a = 0, c_hs_a = 0, c_ls_a = 0;
  int c_von_b = 0, c_vs_b = 0, c_hs_b = 0, c_fs_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs n clks after reset release: tick k lands at clk k*div,
  // tick 1 shows pixel 0, tick k shows raster pixel k-1.
  function automatic exp_t model(input int n, input int div, input int hv, input int hf,
                                 input int hsw, input int hb, input int vv, input int vf,
                                 input int vsw, input int vb, input bit pol);
    exp_t e;
    int k, idx, htot, vtot;
    htot = hv + hf + hsw + hb;
    vtot = vv + vf + vsw + vb;
    e.tick = (n > 0) && (n % div == 0);
    k = n / div;
    if (k == 0) begin
      e.x = 0; e.y = 0; e.von = 0; e.hs = ~pol; e.vs = ~pol; e.ls = 0; e.fs = 0;
    end else begin
      idx   = k - 1;
      e.x   = idx % htot;
      e.y   = (idx / htot) % vtot;
      e.von = (e.x < hv) && (e.y < vv);
      e.hs  = (e.x >= hv + hf && e.x < hv + hf + hsw) ? pol : ~pol;
      e.vs  = (e.y >= vv + vf && e.y < vv + vf + vsw) ? pol : ~pol;
      e.ls  = e.tick && (k >= 2) && (e.x == 0);
      e.fs  = e.ls && (e.y == 0);
    end
    return e;
  endfunction

  function automatic exp_t model_a(input int n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic exp_t model_b(input int n);
    return model(n, 1, 20, 3, 5, 4, 10, 2, 2, 3, 1'b1);
  endfunction

  task automatic compare_all(input bit ra);
    exp_t ea, eb;
    ea = model_a(n_a);
    eb = model_b(n_b);
    check("a_tick", 32'(p_tick_a), 32'(ea.tick));
    check("a_x",    32'(pixel_x_a), 32'(ea.x));
    check("a_y",    32'(pixel_y_a), 32'(ea.y));
    check("a_von",  32'(video_on_a), 32'(ea.von));
    check("a_hs",   32'(hsync_a), 32'(ea.hs));
    check("a_vs",   32'(vsync_a), 32'(ea.vs));
    check("a_ls",   32'(line_start_a), 32'(ea.ls));
    check("a_fs",   32'(frame_start_a), 32'(ea.fs));
    check("b_tick", 32'(p_tick_b), 32'(eb.tick));
    check("b_x",    32'(pixel_x_b), 32'(eb.x));
    check("b_y",    32'(pixel_y_b), 32'(eb.y));
    check("b_von",  32'(video_on_b), 32'(eb.von));
    check("b_hs",   32'(hsync_b), 32'(eb.hs));
    check("b_vs",   32'(vsync_b), 32'(eb.vs));
    check("b_ls",   32'(line_start_b), 32'(eb.ls));
    check("b_fs",   32'(frame_start_b), 32'(eb.fs));
    // Blank/sync must agree with position as observed, not only as modelled
    check("a_von_pos", 32'(video_on_a), 32'(pixel_x_a < 10'd640 && pixel_y_a < 10'd480 && n_a >= 4));
    if (have_prev && !ra && !p_tick_a)
      check("a_stable", 32'({pixel_x_a, pixel_y_a, video_on_a, hsync_a, vsync_a}), 32'(prev_a));
    prev_a    = {pixel_x_a, pixel_y_a, video_on_a, hsync_a, vsync_a};
    have_prev = 1'b1;
    if (win) begin
      if (p_tick_a && n_a >= 4 && n_a <= 4 * 800) begin
        c_von_a += int'(video_on_a);
        c_hs_a  += int'(!hsync_a);
      end
      if (n_a >= 4 && n_a <= 4 * 801) c_ls_a += int'(line_start_a);
      if (n_b >= 1 && n_b <= 544) begin
        c_von_b += int'(video_on_b);
        c_vs_b  += int'(vsync_b);
        c_hs_b  += int'(hsync_b);
      end
      if (n_b >= 1 && n_b <= 545) c_fs_b += int'(frame_start_b);
    end
  endtask

  task automatic step(input bit ra, input bit rb);
    rst_a = ra;
    rst_b = rb;
    @(posedge clk);
    n_a = ra ? 0 : n_a + 1;
    n_b = rb ? 0 : n_b + 1;
    @(negedge clk);
    compare_all(ra);
  endtask

  initial begin
    bit found;
    exp_t e;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) step(1'b1, 1'b1);

    // One full line on the default instance and one full frame on the small one
    win = 1'b1;
    repeat (3210) step(1'b0, 1'b0);
    win = 1'b0;
    check("line_von_ticks", 32'(c_von_a), 32'd640);
    check("line_hs_ticks",  32'(c_hs_a),  32'd96);
    check("line_ls_count",  32'(c_ls_a),  32'd1);
    check("frame_von_b",    32'(c_von_b), 32'd200);
    check("frame_vs_b",     32'(c_vs_b),  32'd64);
    check("frame_hs_b",     32'(c_hs_b),  32'd85);
    check("frame_fs_b",     32'(c_fs_b),  32'd1);

    // Reset mid-hsync, between divider ticks
    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      step(1'b0, 1'b0);
      e = model_a(n_a);
      if (e.tick && e.x == 700) found = 1'b1;
    end
    if (!found) check("reach_x700", 32'(pixel_x_a), 32'd700);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("pre_rst_hs", 32'(hsync_a), 32'd0);
    step(1'b1, 1'b0);
    check("rst_x",   32'(pixel_x_a), 32'd0);
    check("rst_y",   32'(pixel_y_a), 32'd0);
    check("rst_hs",  32'(hsync_a), 32'd1);
    check("rst_vs",  32'(vsync_a), 32'd1);
    check("rst_von", 32'(video_on_a), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0);
      check("rst_tick", 32'(p_tick_a), 32'(i == 4));
      check("rst_von_exit", 32'(video_on_a), 32'(i == 4));
    end

    // Random reset pulses of random length on both instances
    for (int i = 0; i < 20000; i++) begin
      bit ra, rb;
      ra = ($urandom_range(0, 1499) == 0);
      rb = ($urandom_range(0, 399) == 0);
      step(ra, rb);
      if (ra || rb) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) step(ra, rb);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator for the 640x480 VGA display path.
- Produces pixel_x, pixel_y and video_on, which feed the border/box/text renderer, and drives hsync/vsync to the connector.
- Divides the system clock into a pixel-rate enable and walks horizontal and vertical counters through the visible area, front porch, sync and back porch.
- Also emits frame-start and line-start strobes for the clock/date/timer update logic.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range 1..16.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VIS, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- p_tick  out  1  pixel enable, one clk wide, every CLK_DIV clks
- pixel_x  out  10  current horizontal count, 0..H_TOT-1
- pixel_y  out  10  current vertical count, 0..V_TOT-1
- video_on  out  1  high when pixel_x<H_VIS and pixel_y<V_VIS
- hsync  out  1  horizontal sync at SYNC_POL level during the sync window
- vsync  out  1  vertical sync at SYNC_POL level during the sync window
- line_start  out  1  one-clk strobe when pixel_x wraps to 0
- frame_start  out  1  one-clk strobe when (pixel_x,pixel_y) wraps to (0,0)

Behaviour:
- Derived totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
- Reset values, held while rst=1:
  - div_cnt=0, p_tick=0, pixel_x=0, pixel_y=0.
  - video_on=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - line_start=frame_start=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick is registered and equals 1 in the clk after div_cnt==CLK_DIV-1.
  - First p_tick is CLK_DIV clks after rst deasserts.
  - CLK_DIV=1: p_tick is high every clk after reset.
- Horizontal counter: advances only on p_tick; at H_TOT-1 it wraps to 0.
- Vertical counter: advances only on p_tick while h wraps; at V_TOT-1 (with h wrap) it wraps to 0.
- Output timing:
  - All outputs are registered and computed from next-state counters, so video_on, hsync and vsync always describe the same (pixel_x,pixel_y) presented in the same clk.
  - Zero skew between position and sync/blank.
  - pixel_x, pixel_y, video_on, hsync and vsync change only in the clk where p_tick=1; they are stable for CLK_DIV clks.
- Sync windows:
  - hsync is active for H_VIS+H_FP <= pixel_x < H_VIS+H_FP+H_SYNC (656..751).
  - vsync is active for V_VIS+V_FP <= pixel_y < V_VIS+V_FP+V_SYNC (490..491).
- Strobes:
  - line_start=1 for exactly the one clk in which pixel_x becomes 0 (coincident with p_tick).
  - frame_start additionally requires pixel_y becoming 0; frame_start implies line_start.
  - No strobes are emitted out of reset: the first line_start/frame_start occurs at the first natural wrap.
- Position at reset exit: the position (0,0) held after reset counts as the first visible pixel. video_on rises with the first p_tick; the counters stay at (0,0) for that tick and advance from the second tick.
- Reset mid-frame: takes effect on the next clk edge regardless of p_tick or divider phase. All outputs return to their reset values, with no partial sync pulse extension.
- Widths: counters are 10 bits; H_TOT and V_TOT must be <=1024, checked by elaboration assertion.

Test Plan:
- Reset then release, CLK_DIV=4 -> p_tick at clks 4,8,12...; pixel_x = 0,1,2 on successive ticks; hsync=vsync=1, video_on=1 from the first tick.
- Run one line -> pixel_x 0..799 then 0; video_on high for 640 ticks; hsync low for ticks 656..751 (96 ticks); line_start pulses once, aligned with pixel_x=0.
- Run one frame -> pixel_y 0..524 then 0; vsync low only on lines 490 and 491 (1600 ticks); frame_start pulses once per 420000 ticks; video_on count = 307200 ticks.
- Assert rst for 1 clk at (x=700,y=491) mid-hsync/vsync -> the next clk shows x=0, y=0, hsync=vsync=1, video_on=0; normal timing resumes with the first p_tick 4 clks after release.
- CLK_DIV=1, SYNC_POL=1 -> p_tick constantly high; pixel_x increments every clk; hsync high for exactly 96 clks per 800.
- Check every clk -> video_on == (pixel_x<640 && pixel_y<480); the outputs never change in a clk with p_tick=0.
